// File: rtl/bfs_path_engine_pkg.sv
// Shared types for the BFS flood-fill path engine: direction codes, FSM
// state encoding and a grid range helper.
package bfs_path_engine_pkg;

  // Stored per-cell direction: the move that steps one cell toward the target
  typedef enum logic [2:0] {
    DirUp    = 3'd0,
    DirLeft  = 3'd1,
    DirDown  = 3'd2,
    DirRight = 3'd3,
    DirNone  = 3'd4,
    DirHere  = 3'd5
  } dir_e;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StClear   = 3'd1,
    StSeed    = 3'd2,
    StPop     = 3'd3,
    StExplore = 3'd4,
    StDone    = 3'd5
  } state_e;

  // Row/column 0 and anything at or beyond limit form the border and are never routable
  function automatic logic coord_ok(int unsigned x, int unsigned y, int unsigned limit);
    return (x != 0) && (y != 0) && (x < limit) && (y < limit);
  endfunction

endpackage

// File: rtl/bfs_queue.sv
// Circular FIFO holding packed {y,x} cells awaiting expansion. Show-ahead:
// pop_data always presents the head entry. Pointers wrap modulo Depth;
// an occupancy counter separates full from empty.
module bfs_queue #(
  parameter int unsigned Width = 10,
  parameter int unsigned Depth = 128
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [Width-1:0]         push_data,
  input  logic                     pop,
  output logic [Width-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   count
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  assign full     = (count_q == (PtrW + 1)'(Depth));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  // Storage array, no reset needed since occupancy gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/bfs_path_engine.sv
// Breadth-first flood fill from a target cell. Every reachable cell ends up
// holding the direction to step toward the target; NUM_QUERY channels read
// that table with one cycle of latency.
// Build option: define BFS_DIAG_EN to build the stat_cycles/stat_maxq
// counters; otherwise those ports are tied to zero.
module bfs_path_engine
  import bfs_path_engine_pkg::*;
#(
  parameter int unsigned COORD_BITS  = 5,
  parameter int unsigned MAP_LIMIT   = 28,
  parameter int unsigned QUEUE_DEPTH = 128,
  parameter int unsigned NUM_QUERY   = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [COORD_BITS-1:0]           tgt_x,
  input  logic [COORD_BITS-1:0]           tgt_y,
  output logic                            busy,
  output logic                            done,
  output logic                            table_valid,
  output logic                            overflow,
  output logic [COORD_BITS-1:0]           wall_x,
  output logic [COORD_BITS-1:0]           wall_y,
  input  logic                            wall_in,
  input  logic [NUM_QUERY*COORD_BITS-1:0] q_x,
  input  logic [NUM_QUERY*COORD_BITS-1:0] q_y,
  output logic [NUM_QUERY*3-1:0]          q_dir,
  output logic [15:0]                     stat_cycles,
  output logic [$clog2(QUEUE_DEPTH):0]    stat_maxq
);

  localparam int unsigned AW    = 2 * COORD_BITS;
  localparam int unsigned CELLS = 1 << AW;
  localparam int unsigned CW    = $clog2(QUEUE_DEPTH) + 1;

  state_e                state_q, state_d;
  logic [AW-1:0]         clr_addr_q, clr_addr_d;
  logic [COORD_BITS-1:0] tgt_x_q, tgt_y_q;
  logic [COORD_BITS-1:0] par_x_q, par_y_q;
  logic [1:0]            nb_q;
  logic                  overflow_q, table_valid_q, done_q;
  logic                  start_acc, ovf_set;

  logic [COORD_BITS-1:0] nb_x, nb_y;
  logic                  nb_ok, nb_visited;

  // Cell table: {visited, dir[2:0]} addressed by {y,x}
  logic [3:0]            cell_mem [CELLS];
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [3:0]            wr_data;

  logic                  push, pop, q_full, q_empty;
  logic [AW-1:0]         push_data, q_rdata;
  logic [CW-1:0]         q_count;

  logic [2:0]            q_dir_q [NUM_QUERY];
  logic [2:0]            q_next  [NUM_QUERY];

  assign start_acc   = (state_q == StIdle) && start;
  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign table_valid = table_valid_q;
  assign overflow    = overflow_q;

  bfs_queue #(
    .Width (AW),
    .Depth (QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (q_rdata),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  // Neighbour of the current parent for offset nb_q (up, left, down, right)
  always_comb begin
    nb_x = par_x_q;
    nb_y = par_y_q;
    unique case (nb_q)
      2'd0:    nb_y = par_y_q - COORD_BITS'(1);
      2'd1:    nb_x = par_x_q - COORD_BITS'(1);
      2'd2:    nb_y = par_y_q + COORD_BITS'(1);
      default: nb_x = par_x_q + COORD_BITS'(1);
    endcase
  end

  assign nb_ok      = coord_ok(32'(nb_x), 32'(nb_y), MAP_LIMIT);
  assign nb_visited = cell_mem[{nb_y, nb_x}][3];

  // Flood FSM next state, table writes, queue control and wall address
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    push       = 1'b0;
    push_data  = {nb_y, nb_x};
    pop        = 1'b0;
    ovf_set    = 1'b0;
    wall_x     = '0;
    wall_y     = '0;
    unique case (state_q)
      StIdle: begin
        clr_addr_d = '0;
        if (start) state_d = StClear;
      end
      StClear: begin
        wr_en      = 1'b1;
        wr_addr    = clr_addr_q;
        wr_data    = {1'b0, 3'(DirNone)};
        clr_addr_d = clr_addr_q + AW'(1);
        if (clr_addr_q == '1) state_d = StSeed;
      end
      StSeed: begin
        wall_x = tgt_x_q;
        wall_y = tgt_y_q;
        if (coord_ok(32'(tgt_x_q), 32'(tgt_y_q), MAP_LIMIT) && !wall_in) begin
          wr_en     = 1'b1;
          wr_addr   = {tgt_y_q, tgt_x_q};
          wr_data   = {1'b1, 3'(DirHere)};
          push      = 1'b1;
          push_data = {tgt_y_q, tgt_x_q};
          state_d   = StPop;
        end else begin
          state_d = StDone;
        end
      end
      StPop: begin
        if (q_empty) begin
          state_d = StDone;
        end else begin
          pop     = 1'b1;
          state_d = StExplore;
        end
      end
      StExplore: begin
        wall_x = nb_x;
        wall_y = nb_y;
        if (nb_ok && !wall_in && !nb_visited) begin
          // A dropped neighbour stays unvisited so it reads as unreachable
          if (q_full) begin
            ovf_set = 1'b1;
          end else begin
            wr_en   = 1'b1;
            wr_addr = {nb_y, nb_x};
            wr_data = {2'b10, nb_q ^ 2'b10};
            push    = 1'b1;
          end
        end
        if (nb_q == 2'd3) state_d = StPop;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Cell table write port
  always_ff @(posedge clk) begin
    if (wr_en) cell_mem[wr_addr] <= wr_data;
  end

  // FSM state, flood context and status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      clr_addr_q    <= '0;
      tgt_x_q       <= '0;
      tgt_y_q       <= '0;
      par_x_q       <= '0;
      par_y_q       <= '0;
      nb_q          <= '0;
      overflow_q    <= 1'b0;
      table_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      if (start_acc) begin
        tgt_x_q <= tgt_x;
        tgt_y_q <= tgt_y;
      end
      if (pop) {par_y_q, par_x_q} <= q_rdata;
      nb_q <= (state_q == StExplore) ? nb_q + 2'd1 : 2'd0;
      if (start_acc)    overflow_q <= 1'b0;
      else if (ovf_set) overflow_q <= 1'b1;
      if (start_acc)                table_valid_q <= 1'b0;
      else if (state_q == StDone)   table_valid_q <= 1'b1;
      done_q <= (state_q == StDone);
    end
  end

  // Query lookup: unreachable, out-of-range or stale table all read as none
  always_comb begin
    for (int i = 0; i < NUM_QUERY; i++) begin
      q_next[i] = 3'(DirNone);
      if (table_valid_q && coord_ok(32'(q_x[i*COORD_BITS +: COORD_BITS]),
                                    32'(q_y[i*COORD_BITS +: COORD_BITS]), MAP_LIMIT)) begin
        q_next[i] = cell_mem[{q_y[i*COORD_BITS +: COORD_BITS],
                              q_x[i*COORD_BITS +: COORD_BITS]}][2:0];
      end
    end
  end

  // Registered query results
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_QUERY; i++) q_dir_q[i] <= 3'(DirNone);
    end else begin
      for (int i = 0; i < NUM_QUERY; i++) q_dir_q[i] <= q_next[i];
    end
  end

  for (genvar g = 0; g < NUM_QUERY; g++) begin : g_qdir
    assign q_dir[g*3 +: 3] = q_dir_q[g];
  end

`ifdef BFS_DIAG_EN
  logic [15:0]   cyc_q;
  logic [CW-1:0] maxq_q;

  // Busy-cycle counter (saturating) and peak queue occupancy of the last flood
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_q  <= '0;
      maxq_q <= '0;
    end else if (start_acc) begin
      cyc_q  <= '0;
      maxq_q <= '0;
    end else begin
      if (busy && (cyc_q != 16'hFFFF)) cyc_q <= cyc_q + 16'd1;
      if (q_count > maxq_q) maxq_q <= q_count;
    end
  end

  assign stat_cycles = cyc_q;
  assign stat_maxq   = maxq_q;
`else
  logic unused_count;
  assign unused_count = ^q_count;
  assign stat_cycles  = '0;
  assign stat_maxq    = '0;
`endif

endmodule

// File: tb/tb_bfs_path_engine.sv
// Directed bench for bfs_path_engine: flood timing, query tables for an open
// map, a walled map and an invalid target, start-while-busy, mid-flood reset
// and queue overflow on a shallow-FIFO instance.
module tb_bfs_path_engine;

  localparam int CB = 5;
  localparam int NQ = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          start2 = 1'b0;
  logic [CB-1:0] tgt_x = '0, tgt_y = '0;
  logic          wall_mode = 1'b0;
  logic [NQ*CB-1:0] q_x = '0, q_y = '0;

  logic          busy, done, table_valid, overflow, wall_in;
  logic [CB-1:0] wall_x, wall_y;
  logic [NQ*3-1:0] q_dir;
  logic [15:0]   stat_cycles;
  logic [7:0]    stat_maxq;

  logic          busy2, done2, tv2, ovf2, wall_in2;
  logic [CB-1:0] wall_x2, wall_y2;
  logic [NQ*3-1:0] q_dir2;
  logic [15:0]   stat_cycles2;
  logic [2:0]    stat_maxq2;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  // Map model: optional solid wall column at x=10
  assign wall_in  = wall_mode && (wall_x == 5'd10);
  assign wall_in2 = wall_mode && (wall_x2 == 5'd10);

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  bfs_path_engine dut (
    .clk (clk), .reset (reset), .start (start), .tgt_x (tgt_x), .tgt_y (tgt_y),
    .busy (busy), .done (done), .table_valid (table_valid), .overflow (overflow),
    .wall_x (wall_x), .wall_y (wall_y), .wall_in (wall_in),
    .q_x (q_x), .q_y (q_y), .q_dir (q_dir),
    .stat_cycles (stat_cycles), .stat_maxq (stat_maxq)
  );

  bfs_path_engine #(.QUEUE_DEPTH (4)) dut_small (
    .clk (clk), .reset (reset), .start (start2), .tgt_x (tgt_x), .tgt_y (tgt_y),
    .busy (busy2), .done (done2), .table_valid (tv2), .overflow (ovf2),
    .wall_x (wall_x2), .wall_y (wall_y2), .wall_in (wall_in2),
    .q_x (q_x), .q_y (q_y), .q_dir (q_dir2),
    .stat_cycles (stat_cycles2), .stat_maxq (stat_maxq2)
  );

  typedef struct {
    int x;
    int y;
    int d;
  } qent_t;

  qent_t tbl [24];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  // Run a flood on the main DUT; n counts edges from the start-sampling edge
  // through the edge that raises done. Optionally re-pulses start mid-flood.
  task automatic flood(input logic [CB-1:0] tx, input logic [CB-1:0] ty,
                       input bit repulse, output int n);
    @(negedge clk);
    tgt_x = tx;
    tgt_y = ty;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    chk("busy_after_start", int'(busy), 1);
    while (!done && n < 20000) begin
      if (repulse && n == 50) begin
        start = 1'b1;
        tgt_x = 5'd5;
        tgt_y = 5'd5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("done_seen", int'(done), 1);
  endtask

  // Apply groups of four entries to the four channels in the same cycle
  task automatic run_group(input int first, input int nvec, input string tag);
    for (int v = 0; v < nvec; v++) begin
      @(negedge clk);
      for (int c = 0; c < NQ; c++) begin
        q_x[c*CB +: CB] = CB'(tbl[first + v*NQ + c].x);
        q_y[c*CB +: CB] = CB'(tbl[first + v*NQ + c].y);
      end
      @(negedge clk);
      for (int c = 0; c < NQ; c++) begin
        chk($sformatf("%s_v%0d_ch%0d", tag, v, c), int'(q_dir[c*3 +: 3]),
            tbl[first + v*NQ + c].d);
      end
    end
  endtask

  initial begin
    int n;
    int base;

    // Open map, target (2,2)
    tbl[0]  = '{2, 5, 0};   tbl[1]  = '{5, 2, 1};   tbl[2]  = '{2, 1, 2};   tbl[3]  = '{1, 2, 3};
    tbl[4]  = '{2, 2, 5};   tbl[5]  = '{1, 1, 3};   tbl[6]  = '{3, 3, 1};   tbl[7]  = '{0, 5, 4};
    tbl[8]  = '{28, 3, 4};  tbl[9]  = '{27, 27, 1}; tbl[10] = '{2, 27, 0};  tbl[11] = '{27, 2, 1};
    // Wall column at x=10, target (2,2)
    tbl[12] = '{15, 5, 4};  tbl[13] = '{9, 5, 1};   tbl[14] = '{11, 1, 4};  tbl[15] = '{10, 5, 4};
    tbl[16] = '{9, 27, 1};  tbl[17] = '{2, 2, 5};   tbl[18] = '{1, 1, 3};   tbl[19] = '{2, 5, 0};
    // Invalid target (0,3)
    tbl[20] = '{2, 2, 4};   tbl[21] = '{9, 5, 4};   tbl[22] = '{1, 1, 4};   tbl[23] = '{27, 27, 4};

    #2 reset = 1'b0;
    #10;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_table_valid", int'(table_valid), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_wall_x", int'(wall_x), 0);
    chk("rst_wall_y", int'(wall_y), 0);
    for (int c = 0; c < NQ; c++) chk($sformatf("rst_qdir_ch%0d", c), int'(q_dir[c*3 +: 3]), 4);
    @(negedge clk);
    reset = 1'b1;

    // Open map with an ignored second start 50 cycles in
    base = done_cnt;
    flood(5'd2, 5'd2, 1'b1, n);
    chk("open_cycles", n, 4673);
    chk("open_table_valid", int'(table_valid), 1);
    chk("open_busy_low", int'(busy), 0);
    chk("open_overflow", int'(overflow), 0);
    @(negedge clk);
    chk("done_pulse_width", int'(done), 0);
    repeat (20) @(negedge clk);
    chk("open_done_count", done_cnt - base, 1);
    run_group(0, 3, "open");

    // Wall column at x=10
    wall_mode = 1'b1;
    flood(5'd2, 5'd2, 1'b0, n);
    chk("wall_cycles", n, 2243);
    run_group(12, 2, "wall");
    wall_mode = 1'b0;

    // Out-of-range target
    flood(5'd0, 5'd3, 1'b0, n);
    chk("invalid_cycles", n, 1027);
    chk("invalid_table_valid", int'(table_valid), 1);
    run_group(20, 1, "invalid");

    // Reset in the middle of a flood
    @(negedge clk);
    tgt_x = 5'd2;
    tgt_y = 5'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    chk("midflood_busy_before", int'(busy), 1);
    reset = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_table_valid", int'(table_valid), 0);
    chk("midrst_done", int'(done), 0);
    for (int c = 0; c < NQ; c++) chk($sformatf("midrst_qdir_ch%0d", c), int'(q_dir[c*3 +: 3]), 4);
    @(negedge clk);
    reset = 1'b1;

    // Shallow FIFO instance on an open map must drop neighbours
    @(negedge clk);
    tgt_x = 5'd2;
    tgt_y = 5'd2;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n = 1;
    while (!done2 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("small_done_seen", int'(done2), 1);
    chk("small_overflow", int'(ovf2), 1);
    chk("small_table_valid", int'(tv2), 1);
    q_x[CB-1:0] = 5'd2;
    q_y[CB-1:0] = 5'd2;
    @(negedge clk);
    @(negedge clk);
    chk("small_target_here", int'(q_dir2[2:0]), 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
